// File: rtl/upg_pkg.sv
// Shared widths and FSM state encoding for the upgrade dump transmitter.
package upg_pkg;

    localparam int ADR_W  = 14;
    localparam int CNT_W  = 15;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } upg_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte, LSB first, each bit held BIT_DIV cycles.
// ready is high when idle and also during the final cycle of the stop bit,
// so a load on that cycle puts the next start bit on the line without a gap.
module uart_tx_byte #(
    parameter int BIT_DIV = 78
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_val,
    output logic       tx,
    output logic       ready
);

    localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       byte_r;
    logic             active;

    assign ready = !active || (bit_idx == 4'd9 && div_cnt == '0);

    // Bit timer counts down per bit; bit_idx 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_idx <= '0;
            byte_r  <= '0;
            active  <= 1'b0;
            tx      <= 1'b1;
        end else if (load) begin
            byte_r  <= byte_val;
            active  <= 1'b1;
            bit_idx <= '0;
            div_cnt <= DIV_LAST;
            tx      <= 1'b0;
        end else if (active) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end else if (bit_idx == 4'd9) begin
                active  <= 1'b0;
                bit_idx <= '0;
                tx      <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                div_cnt <= DIV_LAST;
                tx      <= (bit_idx == 4'd8) ? 1'b1 : byte_r[bit_idx[2:0]];
            end
        end
    end

endmodule

// File: rtl/upg_dump_tx.sv
// Dumps a block of 32-bit memory words over a UART, little-endian per word.
// One memory read per word, then four back-to-back 8N1 bytes. After the last
// word the line rests idle-high for one cycle in SEND before the done pulse.
module upg_dump_tx
    import upg_pkg::*;
#(
    parameter int BIT_DIV = 78
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic              start_i,
    input  logic [ADR_W-1:0]  base_adr_i,
    input  logic [CNT_W-1:0]  word_cnt_i,
    output logic              mem_rd_o,
    output logic [ADR_W-1:0]  mem_adr_o,
    input  logic [DATA_W-1:0] mem_dat_i,
    output logic              upg_tx_o,
    output logic              busy_o,
    output logic              done_o
);

    upg_state_t        state;
    logic [CNT_W-1:0]  words_left;
    logic [DATA_W-1:0] word_r;
    logic [2:0]        byte_sel;
    logic              tail;
    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              tx_ready;

    uart_tx_byte #(.BIT_DIV(BIT_DIV)) u_tx (
        .clk      (upg_clk_i),
        .rst      (upg_rst_i),
        .load     (tx_load),
        .byte_val (tx_byte),
        .tx       (upg_tx_o),
        .ready    (tx_ready)
    );

    // Byte 0 is loaded straight from the read data so its start bit follows CAPTURE.
    always_comb begin
        tx_load = 1'b0;
        tx_byte = 8'h00;
        if (state == ST_CAPTURE) begin
            tx_load = 1'b1;
            tx_byte = mem_dat_i[7:0];
        end else if (state == ST_SEND && tx_ready && !tail && byte_sel != 3'd4) begin
            tx_load = 1'b1;
            case (byte_sel[1:0])
                2'd1:    tx_byte = word_r[15:8];
                2'd2:    tx_byte = word_r[23:16];
                2'd3:    tx_byte = word_r[31:24];
                default: tx_byte = word_r[7:0];
            endcase
        end
    end

    // Word/byte sequencer with registered strobes and status.
    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state      <= ST_IDLE;
            words_left <= '0;
            word_r     <= '0;
            byte_sel   <= '0;
            tail       <= 1'b0;
            mem_rd_o   <= 1'b0;
            mem_adr_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            mem_rd_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (word_cnt_i != '0) begin
                            mem_adr_o  <= base_adr_i;
                            words_left <= word_cnt_i;
                            mem_rd_o   <= 1'b1;
                            state      <= ST_FETCH;
                        end else begin
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    words_left <= words_left - CNT_W'(1);
                    state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word_r   <= mem_dat_i;
                    byte_sel <= 3'd1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tail) begin
                        tail   <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else if (tx_ready) begin
                        if (byte_sel != 3'd4) begin
                            byte_sel <= byte_sel + 3'd1;
                        end else if (words_left != '0) begin
                            mem_adr_o <= mem_adr_o + ADR_W'(1);
                            mem_rd_o  <= 1'b1;
                            state     <= ST_FETCH;
                        end else begin
                            tail <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upg_dump_tx.sv
// Self-checking bench for upg_dump_tx with BIT_DIV=4.
module tb_upg_dump_tx;

    localparam int BIT_DIV  = 4;
    localparam int WORD_CYC = 40 * BIT_DIV + 2;

    logic        upg_clk_i = 1'b0;
    logic        upg_rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [13:0] base_adr_i = '0;
    logic [14:0] word_cnt_i = '0;
    logic        mem_rd_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat_i;
    logic        upg_tx_o;
    logic        busy_o;
    logic        done_o;

    logic [31:0] mem [16384];
    bit          exp_tx[$];
    int          exp_done;
    int          n_cmp = 0;
    int          n_err = 0;

    upg_dump_tx #(.BIT_DIV(BIT_DIV)) dut (
        .upg_clk_i  (upg_clk_i),
        .upg_rst_i  (upg_rst_i),
        .start_i    (start_i),
        .base_adr_i (base_adr_i),
        .word_cnt_i (word_cnt_i),
        .mem_rd_o   (mem_rd_o),
        .mem_adr_o  (mem_adr_o),
        .mem_dat_i  (mem_dat_i),
        .upg_tx_o   (upg_tx_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 upg_clk_i = ~upg_clk_i;

    // Synchronous memory: data valid only the cycle after a read, garbage otherwise.
    always @(posedge upg_clk_i) mem_dat_i <= mem_rd_o ? mem[mem_adr_o] : $urandom;

    // Expected line level per cycle after the start edge (index = cycle number).
    task automatic build_model(input logic [13:0] base, input int cnt);
        logic [31:0] w;
        logic [7:0]  b8;
        logic [13:0] a;
        bit          lvl;
        exp_tx.delete();
        exp_tx.push_back(1'b1);
        a = base;
        for (int k = 0; k < cnt; k++) begin
            w = mem[a];
            a = a + 14'd1;
            exp_tx.push_back(1'b1);
            exp_tx.push_back(1'b1);
            for (int bi = 0; bi < 4; bi++) begin
                b8 = w[8*bi +: 8];
                for (int t = 0; t < 10; t++) begin
                    if (t == 0) lvl = 1'b0;
                    else if (t == 9) lvl = 1'b1;
                    else lvl = b8[t-1];
                    repeat (BIT_DIV) exp_tx.push_back(lvl);
                end
            end
        end
        exp_done = (cnt == 0) ? 1 : 2 + cnt * WORD_CYC;
        while (exp_tx.size() < exp_done + 3) exp_tx.push_back(1'b1);
    endtask

    task automatic run_dump(input string name, input logic [13:0] base, input int cnt,
                            input int inj_a, input int inj_b);
        int e_tx = 0, e_rd = 0, e_adr = 0, e_done = 0, e_busy = 0;
        int f_tx = 0, f_rd = 0, f_adr = 0, f_done = 0, f_busy = 0;
        logic [13:0] g_adr = '0, w_adr = '0;
        bit exp_rd;
        logic [13:0] exp_adr;
        int k;
        build_model(base, cnt);
        @(negedge upg_clk_i);
        base_adr_i = base;
        word_cnt_i = cnt[14:0];
        start_i = 1'b1;
        @(posedge upg_clk_i);
        for (int c = 1; c <= exp_done + 2; c++) begin
            @(negedge upg_clk_i);
            start_i = 1'b0;
            k = (c - 1) / WORD_CYC;
            exp_rd = (k < cnt) && ((c - 1) % WORD_CYC == 0);
            exp_adr = base + 14'(k);
            if (upg_tx_o !== exp_tx[c]) begin e_tx++; if (f_tx == 0) f_tx = c; end
            if (mem_rd_o !== exp_rd) begin e_rd++; if (f_rd == 0) f_rd = c; end
            if (exp_rd && mem_adr_o !== exp_adr) begin
                e_adr++;
                if (f_adr == 0) begin f_adr = c; g_adr = mem_adr_o; w_adr = exp_adr; end
            end
            if (done_o !== (c == exp_done)) begin e_done++; if (f_done == 0) f_done = c; end
            if (busy_o !== (c <= exp_done)) begin e_busy++; if (f_busy == 0) f_busy = c; end
            if (c == inj_a || c == inj_b) begin
                base_adr_i = 14'($urandom);
                word_cnt_i = 15'($urandom_range(1, 5));
                start_i = 1'b1;
            end
        end
        start_i = 1'b0;
        n_cmp++;
        if (e_tx != 0) begin
            n_err++;
            $display("FAIL %s tx_line: %0d cycles wrong, first at cycle %0d (want %b)",
                     name, e_tx, f_tx, exp_tx[f_tx]);
        end
        n_cmp++;
        if (e_rd != 0) begin
            n_err++;
            $display("FAIL %s mem_rd: %0d cycles wrong, first at cycle %0d", name, e_rd, f_rd);
        end
        n_cmp++;
        if (e_adr != 0) begin
            n_err++;
            $display("FAIL %s mem_adr: cycle %0d got %h want %h", name, f_adr, g_adr, w_adr);
        end
        n_cmp++;
        if (e_done != 0) begin
            n_err++;
            $display("FAIL %s done: %0d cycles wrong, first at cycle %0d, want pulse at %0d",
                     name, e_done, f_done, exp_done);
        end
        n_cmp++;
        if (e_busy != 0) begin
            n_err++;
            $display("FAIL %s busy: %0d cycles wrong, first at cycle %0d", name, e_busy, f_busy);
        end
    endtask

    task automatic test_reset();
        upg_rst_i = 1'b1;
        start_i = 1'b1;
        repeat (3) @(negedge upg_clk_i);
        n_cmp++; if (upg_tx_o !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", upg_tx_o); end
        n_cmp++; if (mem_rd_o !== 1'b0) begin n_err++; $display("FAIL reset_rd got %b want 0", mem_rd_o); end
        n_cmp++; if (mem_adr_o !== 14'h0) begin n_err++; $display("FAIL reset_adr got %h want 0", mem_adr_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
        start_i = 1'b0;
        upg_rst_i = 1'b0;
        repeat (2) @(negedge upg_clk_i);
    endtask

    task automatic test_single_word();
        mem[14'h0010] = 32'h12345678;
        run_dump("single", 14'h0010, 1, 0, 0);
    endtask

    task automatic test_zero_count();
        run_dump("zero_cnt", 14'($urandom), 0, 0, 0);
    endtask

    task automatic test_wrap();
        run_dump("wrap", 14'h3FFF, 2, 0, 0);
    endtask

    task automatic test_byte_55();
        mem[14'h0200] = 32'h55555555;
        run_dump("byte55", 14'h0200, 1, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_dump("start_ignored", 14'h1234, 2, 100, 2 + 2 * WORD_CYC);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_dump("random", 14'($urandom), $urandom_range(1, 3), 0, 0);
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        @(negedge upg_clk_i);
        base_adr_i = 14'h0100;
        word_cnt_i = 15'd1;
        start_i = 1'b1;
        @(posedge upg_clk_i);
        // Cycle 44 lies inside byte 1's start bit (cycles 43..46).
        for (int c = 1; c <= 44; c++) begin
            @(negedge upg_clk_i);
            start_i = 1'b0;
        end
        n_cmp++; if (upg_tx_o !== 1'b0) begin n_err++; $display("FAIL midrst_pre_tx got %b want 0", upg_tx_o); end
        upg_rst_i = 1'b1;
        #1;
        n_cmp++; if (upg_tx_o !== 1'b1) begin n_err++; $display("FAIL midrst_tx got %b want 1", upg_tx_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy_o); end
        repeat (2) @(negedge upg_clk_i);
        upg_rst_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge upg_clk_i);
            if (done_o !== 1'b0 || upg_tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midrst_quiet: %0d cycles with activity, want 0", bad);
        end
        run_dump("after_reset", 14'($urandom), 1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        test_reset();
        test_single_word();
        test_zero_count();
        test_wrap();
        test_byte_55();
        test_start_ignored();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
